// File: rtl/me_collect_pkg.sv
// me_collect_pkg
// Shared definitions for the motion-estimation result collector:
//   - default SAD / sequence-tag widths
//   - ch_w(n): width of a channel index, never less than one bit
//   - fifo_entry_t: layout of one buffered result {sad, seq} at default widths
//   - out_state_t: states of the single output register
package me_collect_pkg;

    localparam int SAD_W_DEF = 22;
    localparam int SEQ_W_DEF = 8;

    function automatic int ch_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [SAD_W_DEF-1:0] sad;
        logic [SEQ_W_DEF-1:0] seq;
    } fifo_entry_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

endpackage

// File: rtl/me_sync_fifo.sv
// me_sync_fifo
// Count-based synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous flush
//   push, din  : write request and data; on a full FIFO the write is taken
//                only when a pop happens in the same cycle
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever empty = 0
//   full, empty: occupancy flags
module me_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/me_result_collector.sv
// me_result_collector
// Collects minimum-SAD results from NUM_CH engines, buffers them per channel,
// tags each with a per-channel sequence number and serialises them onto one
// valid/ready stream with round-robin arbitration.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   clr                 : synchronous clear of FIFOs, tags, flags and arbiter
//   in_sad, in_fin      : packed per-channel SAD and finish strobes
//   out_valid/out_ready : output handshake
//   out_sad/out_ch/out_seq : output word
//   overflow            : sticky per-channel drop flags
//   res_cnt             : per-channel delivered-word counters, saturating,
//                         present only when ME_COLLECT_STATS_EN is defined
module me_result_collector
    import me_collect_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SAD_W  = SAD_W_DEF,
    parameter int DEPTH  = 4,
    parameter int SEQ_W  = SEQ_W_DEF
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [NUM_CH*SAD_W-1:0] in_sad,
    input  logic [NUM_CH-1:0]       in_fin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAD_W-1:0]        out_sad,
    output logic [ch_w(NUM_CH)-1:0] out_ch,
    output logic [SEQ_W-1:0]        out_seq,
    output logic [NUM_CH-1:0]       overflow
`ifdef ME_COLLECT_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]    res_cnt
`endif
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int ENT_W = SAD_W + SEQ_W;

    out_state_t                      state;
    logic [CH_W-1:0]                 rr;
    logic [NUM_CH-1:0][SEQ_W-1:0]    seq;
    logic [NUM_CH-1:0][ENT_W-1:0]    head;
    logic [NUM_CH-1:0]               avail;
    logic [NUM_CH-1:0]               drop;
    logic [CH_W-1:0]                 grant;
    logic [CH_W-1:0]                 grant_hi;
    logic [CH_W-1:0]                 grant_lo;
    logic [CH_W-1:0]                 rr_next;
    logic                            found_hi;
    logic                            found_lo;
    logic                            any_avail;
    logic                            load;

    // Round-robin grant: lowest available channel at or above rr wins,
    // otherwise the lowest available channel below rr (the wrap-around).
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (avail[k]) begin
                if (CH_W'(k) >= rr) begin
                    grant_hi = CH_W'(k);
                    found_hi = 1'b1;
                end else begin
                    grant_lo = CH_W'(k);
                    found_lo = 1'b1;
                end
            end
        end
        grant     = found_hi ? grant_hi : grant_lo;
        any_avail = found_hi | found_lo;
    end

    assign rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

    // The output register takes a new word when it is empty or being drained.
    assign load = !clr && any_avail && ((state == ST_EMPTY) || out_ready);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ENT_W-1:0] din;
        logic [ENT_W-1:0] dout;
        logic             full;
        logic             empty;
        logic             sel;
        logic             push;
        logic             pop;

        assign din = {in_sad[k*SAD_W +: SAD_W], seq[k]};
        assign sel = load && (grant == CH_W'(k));
        // An incoming result on an empty, granted channel bypasses the FIFO
        // straight into the output register, giving one-cycle latency.
        assign pop       = sel && !empty;
        assign push      = in_fin[k] && !clr && !(sel && empty);
        assign head[k]   = empty ? din : dout;
        assign avail[k]  = !empty || in_fin[k];
        assign drop[k]   = push && full && !pop;

        me_sync_fifo #(
            .W     (ENT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .push  (push),
            .din   (din),
            .pop   (pop),
            .dout  (dout),
            .full  (full),
            .empty (empty)
        );
    end

    // Tags advance on every strobe, including dropped ones, so gaps show
    // where results were lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq      <= '0;
            overflow <= '0;
        end else if (clr) begin
            seq      <= '0;
            overflow <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (in_fin[k]) seq[k] <= seq[k] + SEQ_W'(1);
                if (drop[k])   overflow[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_ch    <= '0;
            out_seq   <= '0;
            rr        <= '0;
        end else if (clr) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            rr        <= '0;
        end else if (load) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_sad   <= head[grant][ENT_W-1 -: SAD_W];
            out_seq   <= head[grant][SEQ_W-1:0];
            out_ch    <= grant;
            rr        <= rr_next;
        end else if ((state == ST_HOLD) && out_ready) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
        end
    end

`ifdef ME_COLLECT_STATS_EN
    logic [NUM_CH-1:0][15:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_valid && out_ready && (out_ch == CH_W'(k)) &&
                    (cnt[k] != 16'hFFFF))
                    cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    assign res_cnt = cnt;
`endif

endmodule

// File: tb/tb_me_result_collector.sv
// tb_me_result_collector
// Directed self-checking bench for me_result_collector at default parameters
// (NUM_CH=2, SAD_W=22, DEPTH=4, SEQ_W=8).
module tb_me_result_collector;

    localparam int NUM_CH = 2;
    localparam int SAD_W  = 22;
    localparam int DEPTH  = 4;
    localparam int SEQ_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    clr = 1'b0;
    logic [NUM_CH*SAD_W-1:0] in_sad = '0;
    logic [NUM_CH-1:0]       in_fin = '0;
    logic                    out_ready = 1'b0;
    logic                    out_valid;
    logic [SAD_W-1:0]        out_sad;
    logic [0:0]              out_ch;
    logic [SEQ_W-1:0]        out_seq;
    logic [NUM_CH-1:0]       overflow;
`ifdef ME_COLLECT_STATS_EN
    logic [NUM_CH*16-1:0]    res_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    me_result_collector #(
        .NUM_CH (NUM_CH),
        .SAD_W  (SAD_W),
        .DEPTH  (DEPTH),
        .SEQ_W  (SEQ_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_sad    (in_sad),
        .in_fin    (in_fin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .out_ch    (out_ch),
        .out_seq   (out_seq),
        .overflow  (overflow)
`ifdef ME_COLLECT_STATS_EN
        ,
        .res_cnt   (res_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sad(input int ch, input logic [SAD_W-1:0] v);
        in_sad[ch*SAD_W +: SAD_W] = v;
    endtask

    task automatic do_clear();
        clr    = 1'b1;
        in_fin = '0;
        step();
        clr    = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_sad !== '0) begin n_fail++; $display("[TB] FAIL reset_sad: got %0d want 0", out_sad); end
        n_cmp++; if (out_ch !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ch: got %0d want 0", out_ch); end
        n_cmp++; if (out_seq !== '0) begin n_fail++; $display("[TB] FAIL reset_seq: got %0d want 0", out_seq); end
        n_cmp++; if (overflow !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b want 00", overflow); end
`ifdef ME_COLLECT_STATS_EN
        n_cmp++; if (res_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_res_cnt: got %h want 0", res_cnt); end
`endif
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_clear();
        out_ready = 1'b1;
        set_sad(0, 22'd1234);
        in_fin = 2'b01;
        step();
        in_fin = 2'b00;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_sad !== 22'd1234) begin n_fail++; $display("[TB] FAIL single_sad: got %0d want 1234", out_sad); end
        n_cmp++; if (out_ch !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ch: got %0d want 0", out_ch); end
        n_cmp++; if (out_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL single_seq: got %0d want 0", out_seq); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        out_ready = 1'b1;
        set_sad(0, 22'd100);
        set_sad(1, 22'd200);
        in_fin = 2'b11;
        step();
        in_fin = 2'b00;
        n_cmp++; if (out_sad !== 22'd100 || out_ch !== 1'b0 || out_seq !== 8'd0)
            begin n_fail++; $display("[TB] FAIL simul_w0: got sad=%0d ch=%0d seq=%0d want 100/0/0", out_sad, out_ch, out_seq); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_sad !== 22'd200 || out_ch !== 1'b1 || out_seq !== 8'd0)
            begin n_fail++; $display("[TB] FAIL simul_w1: got v=%b sad=%0d ch=%0d seq=%0d want 1/200/1/0", out_valid, out_sad, out_ch, out_seq); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_drain: got %b want 0", out_valid); end
        // rr is back at 0, so a second pair again starts with channel 0
        in_fin = 2'b11;
        step();
        in_fin = 2'b00;
        n_cmp++; if (out_ch !== 1'b0 || out_seq !== 8'd1)
            begin n_fail++; $display("[TB] FAIL simul_rr: got ch=%0d seq=%0d want 0/1", out_ch, out_seq); end
        step();
        n_cmp++; if (out_ch !== 1'b1 || out_seq !== 8'd1)
            begin n_fail++; $display("[TB] FAIL simul_rr2: got ch=%0d seq=%0d want 1/1", out_ch, out_seq); end
        step();
    endtask

    task automatic test_overflow();
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_sad(1, SAD_W'(10 + i));
            in_fin = 2'b10;
            step();
        end
        in_fin = 2'b00;
        n_cmp++; if (overflow !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b want 10", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 1'b1 || out_seq !== SEQ_W'(i) || out_sad !== SAD_W'(10 + i)) begin
                n_fail++;
                $display("[TB] FAIL ovf_word%0d: got v=%b ch=%0d seq=%0d sad=%0d want 1/1/%0d/%0d",
                         i, out_valid, out_ch, out_seq, out_sad, i, 10 + i);
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drain: got %b want 0", out_valid); end
        set_sad(1, 22'd77);
        in_fin = 2'b10;
        step();
        in_fin = 2'b00;
        n_cmp++; if (out_seq !== 8'd6 || out_sad !== 22'd77)
            begin n_fail++; $display("[TB] FAIL ovf_gap: got seq=%0d sad=%0d want 6/77", out_seq, out_sad); end
        n_cmp++; if (overflow !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b want 10", overflow); end
        step();
    endtask

    task automatic test_fairness();
        do_clear();
        out_ready = 1'b1;
        set_sad(0, 22'd500);
        set_sad(1, 22'd600);
        for (int i = 0; i < 16; i++) begin
            in_fin = (i < 8) ? 2'b11 : 2'b00;
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 1'(i % 2) || out_seq !== SEQ_W'(i / 2) ||
                out_sad !== ((i % 2 == 0) ? 22'd500 : 22'd600)) begin
                n_fail++;
                $display("[TB] FAIL fair_word%0d: got v=%b ch=%0d seq=%0d sad=%0d want 1/%0d/%0d/%0d",
                         i, out_valid, out_ch, out_seq, out_sad, i % 2, i / 2, (i % 2 == 0) ? 500 : 600);
            end
        end
        in_fin = 2'b00;
        n_cmp++; if (overflow !== 2'b00) begin n_fail++; $display("[TB] FAIL fair_overflow: got %b want 00", overflow); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fair_drain: got %b want 0", out_valid); end
`ifdef ME_COLLECT_STATS_EN
        n_cmp++; if (res_cnt !== {16'd8, 16'd8}) begin n_fail++; $display("[TB] FAIL fair_res_cnt: got %h want 00080008", res_cnt); end
`endif
    endtask

    task automatic test_clear();
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_sad(0, SAD_W'(1 + i));
            in_fin = 2'b01;
            step();
        end
        in_fin = 2'b00;
        n_cmp++; if (overflow !== 2'b01) begin n_fail++; $display("[TB] FAIL clr_pre_ovf: got %b want 01", overflow); end
        // a strobe coinciding with clr must be discarded
        set_sad(0, 22'd999);
        in_fin = 2'b01;
        clr    = 1'b1;
        step();
        clr    = 1'b0;
        in_fin = 2'b00;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_valid: got %b want 0", out_valid); end
        n_cmp++; if (overflow !== 2'b00) begin n_fail++; $display("[TB] FAIL clr_overflow: got %b want 00", overflow); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_empty: got %b want 0", out_valid); end
        out_ready = 1'b1;
        set_sad(0, 22'd42);
        in_fin = 2'b01;
        step();
        in_fin = 2'b00;
        n_cmp++; if (out_valid !== 1'b1 || out_sad !== 22'd42 || out_seq !== 8'd0)
            begin n_fail++; $display("[TB] FAIL clr_next: got v=%b sad=%0d seq=%0d want 1/42/0", out_valid, out_sad, out_seq); end
        step();
    endtask

    task automatic test_async_reset();
        do_clear();
        out_ready = 1'b1;
        set_sad(1, 22'd5);
        in_fin = 2'b10;
        step();
        in_fin = 2'b00;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_sad(1, 22'd999);
            in_fin = 2'b10;
            step();
        end
        in_fin = 2'b00;
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 1'b1 || overflow !== 2'b10)
            begin n_fail++; $display("[TB] FAIL arst_pre: got v=%b ch=%0d ovf=%b want 1/1/10", out_valid, out_ch, overflow); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_sad !== '0 || out_ch !== 1'b0 || out_seq !== '0)
            begin n_fail++; $display("[TB] FAIL arst_data: got sad=%0d ch=%0d seq=%0d want 0/0/0", out_sad, out_ch, out_seq); end
        n_cmp++; if (overflow !== 2'b00) begin n_fail++; $display("[TB] FAIL arst_overflow: got %b want 00", overflow); end
`ifdef ME_COLLECT_STATS_EN
        n_cmp++; if (res_cnt !== '0) begin n_fail++; $display("[TB] FAIL arst_res_cnt: got %h want 0", res_cnt); end
`endif
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_flushed: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_fairness();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
